texture_stage_sequencer: RTL
============================

TEXTURE_STAGE_SEQUENCER -- requirements
Module: texture_stage_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 2, number of texture stages (1..4) applied per fragment.
REQ-002 SHALL have parameter USER_WIDTH, default 1, width of the sideband passed from input to output.
REQ-003 SHALL have parameter PIXEL_WIDTH, default 32, RGBA colour width.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port aclk  in  1  clock.
REQ-006 SHALL have port reset  in  1  synchronous active-high reset.
REQ-007 SHALL have port confStageEnable  in  NUM_STAGES  per-stage enable; bit i enables stage i.
REQ-008 SHALL have ports s_valid in 1, s_ready out 1, s_user in USER_WIDTH, s_primaryColor in PIXEL_WIDTH, s_textureST in NUM_STAGES*64: fragment input; stage i S at [64i+32 +: 32], T at [64i +: 32].
REQ-009 SHALL have ports tmu_s_valid out 1, tmu_s_ready in 1, tmu_s_stage out max(1,clog2(NUM_STAGES)), tmu_s_primaryColor out PIXEL_WIDTH, tmu_s_previousColor out PIXEL_WIDTH, tmu_s_textureS out 32, tmu_s_textureT out 32: request to the shared TMU.
REQ-010 SHALL have ports tmu_m_valid in 1, tmu_m_ready out 1, tmu_m_fragmentColor in PIXEL_WIDTH: TMU result.
REQ-011 SHALL have ports m_valid out 1, m_ready in 1, m_user out USER_WIDTH, m_fragmentColor out PIXEL_WIDTH: fragment output.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, OUTPUT; one fragment in flight at a time.
REQ-013 SHALL assert s_ready only in IDLE; all other states SHALL hold s_ready=0.
REQ-014 On s_valid&&s_ready SHALL latch s_user, s_primaryColor, s_textureST and snapshot confStageEnable; previousColor register := s_primaryColor.
REQ-015 Config changes after acceptance SHALL not affect the in-flight fragment.
REQ-016 After acceptance SHALL select the lowest enabled stage index; if none enabled go to OUTPUT with m_fragmentColor = primary colour (bypass).
REQ-017 ISSUE: tmu_s_valid=1, tmu_s_stage = current stage, S/T from that stage's slice, previousColor = register, primaryColor = latched; on tmu_s_valid&&tmu_s_ready go to WAIT; tmu_s_* payload SHALL be stable while tmu_s_valid=1 and not ready.
REQ-018 WAIT: tmu_m_ready=1; tmu_m_ready SHALL be 0 in all other states; on tmu_m_valid: previousColor := tmu_m_fragmentColor, advance to next higher enabled stage and go to ISSUE, or to OUTPUT if none remains.
REQ-019 OUTPUT: m_valid=1, m_fragmentColor = previousColor, m_user = latched user; payload stable until m_valid&&m_ready, then go to IDLE.
REQ-020 Skipped (disabled) stages SHALL cost zero cycles; stage search is combinational over the snapshot.
REQ-021 Latency from input handshake to m_valid (zero-stall TMU with response latency L cycles after request handshake): E*(1+L)+1 cycles, E = number of enabled stages; bypass = 1 cycle.
REQ-022 Back-pressure: stalls on tmu_s_ready=0 or m_ready=0 SHALL add cycles one-for-one and lose no data.
REQ-023 tmu_m_valid outside WAIT SHALL be ignored (not consumed, no state change).
REQ-024 Stage index SHALL never exceed NUM_STAGES-1; no wrap-around to stage 0 within a fragment.

Reset
REQ-025 While reset=1 SHALL force state IDLE, s_ready=0, tmu_s_valid=0, tmu_m_ready=0, m_valid=0, m_fragmentColor=0, m_user=0, stage=0, previousColor=0.
REQ-026 First cycle after reset deasserts SHALL present s_ready=1.
REQ-027 Reset asserted mid-fragment (any state) SHALL abandon the fragment; no m_valid for it afterwards.

Verification
REQ-028 NUM_STAGES=2, enable=2'b11, primary=0x11223344, TMU model returns previous+0x01010101 after L=3 -> m_fragmentColor=0x13243546, m_valid 9 cycles after input handshake, tmu_s_stage sequence 0,1.
REQ-029 enable=2'b00, primary=0xAABBCCDD, user=1 -> m_valid 1 cycle after handshake, m_fragmentColor=0xAABBCCDD, m_user=1, no tmu_s_valid pulse.
REQ-030 enable=2'b10 -> exactly one TMU request with tmu_s_stage=1 and S/T = s_textureST[127:64]; toggling enable to 2'b01 during WAIT changes nothing.
REQ-031 Hold tmu_s_ready=0 for 5 cycles and m_ready=0 for 4 cycles -> payloads stable throughout, latency grows by exactly 9, result unchanged; s_ready stays 0 until output handshake.
REQ-032 Assert reset for 1 cycle while in WAIT -> all outputs at REQ-025 values, s_ready=1 next cycle, late tmu_m_valid ignored, next fragment processed correctly.

Source files
------------

// File: rtl/texture_stage_sequencer_if.sv
// Fragment-in, TMU request/response and fragment-out channels of the texture stage sequencer.
// slave is the sequencer's view; master is the surrounding pipeline and TMU.
interface texture_stage_sequencer_if #(
  parameter int NUM_STAGES  = 2,
  parameter int USER_WIDTH  = 1,
  parameter int PIXEL_WIDTH = 32
);
  localparam int STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic                     s_valid;
  logic                     s_ready;
  logic [USER_WIDTH-1:0]    s_user;
  logic [PIXEL_WIDTH-1:0]   s_primaryColor;
  logic [NUM_STAGES*64-1:0] s_textureST;

  logic                     tmu_s_valid;
  logic                     tmu_s_ready;
  logic [STAGE_W-1:0]       tmu_s_stage;
  logic [PIXEL_WIDTH-1:0]   tmu_s_primaryColor;
  logic [PIXEL_WIDTH-1:0]   tmu_s_previousColor;
  logic [31:0]              tmu_s_textureS;
  logic [31:0]              tmu_s_textureT;

  logic                     tmu_m_valid;
  logic                     tmu_m_ready;
  logic [PIXEL_WIDTH-1:0]   tmu_m_fragmentColor;

  logic                     m_valid;
  logic                     m_ready;
  logic [USER_WIDTH-1:0]    m_user;
  logic [PIXEL_WIDTH-1:0]   m_fragmentColor;

  modport slave (
    input  s_valid, s_user, s_primaryColor, s_textureST,
    input  tmu_s_ready, tmu_m_valid, tmu_m_fragmentColor, m_ready,
    output s_ready, tmu_s_valid, tmu_s_stage, tmu_s_primaryColor, tmu_s_previousColor,
    output tmu_s_textureS, tmu_s_textureT, tmu_m_ready, m_valid, m_user, m_fragmentColor
  );

  modport master (
    output s_valid, s_user, s_primaryColor, s_textureST,
    output tmu_s_ready, tmu_m_valid, tmu_m_fragmentColor, m_ready,
    input  s_ready, tmu_s_valid, tmu_s_stage, tmu_s_primaryColor, tmu_s_previousColor,
    input  tmu_s_textureS, tmu_s_textureT, tmu_m_ready, m_valid, m_user, m_fragmentColor
  );
endinterface

// File: rtl/texture_stage_sequencer.sv
// Walks one fragment through its enabled texture stages on a shared TMU, feeding each
// stage's result forward as the next stage's previous colour.
module texture_stage_sequencer #(
  parameter int NUM_STAGES  = 2,
  parameter int USER_WIDTH  = 1,
  parameter int PIXEL_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic [NUM_STAGES-1:0] confStageEnable,
  texture_stage_sequencer_if.slave bus
);
  localparam int STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} state_t;

  state_t                   state_q, state_d;
  logic [NUM_STAGES-1:0]    en_q;
  logic [USER_WIDTH-1:0]    user_q;
  logic [PIXEL_WIDTH-1:0]   prim_q, prev_q;
  logic [NUM_STAGES*64-1:0] tex_q;
  logic [STAGE_W-1:0]       stage_q;

  logic                     first_found, next_found;
  logic [STAGE_W-1:0]       first_idx, next_idx;
  logic [63:0]              st_sel;
  logic                     in_hs, rsp_hs;

  assign in_hs  = bus.s_valid && (state_q == IDLE);
  assign rsp_hs = bus.tmu_m_valid && (state_q == WAIT);

  // First stage comes from the live config at acceptance; later stages only from the snapshot.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = NUM_STAGES-1; i >= 0; i--) begin
      if (confStageEnable[i]) begin
        first_found = 1'b1;
        first_idx   = STAGE_W'(i);
      end
      if (en_q[i] && (i > int'(stage_q))) begin
        next_found = 1'b1;
        next_idx   = STAGE_W'(i);
      end
    end
  end

  always_comb begin
    st_sel = '0;
    for (int i = 0; i < NUM_STAGES; i++)
      if (stage_q == STAGE_W'(i)) st_sel = tex_q[i*64 +: 64];
  end

  always_ff @(posedge aclk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (in_hs) state_d = first_found ? ISSUE : OUTPUT;
      ISSUE:  if (bus.tmu_s_ready) state_d = WAIT;
      WAIT:   if (bus.tmu_m_valid) state_d = next_found ? ISSUE : OUTPUT;
      OUTPUT: if (bus.m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, even before the registers clear.
  always_comb begin
    bus.s_ready             = 1'b0;
    bus.tmu_s_valid         = 1'b0;
    bus.tmu_m_ready         = 1'b0;
    bus.m_valid             = 1'b0;
    bus.tmu_s_stage         = '0;
    bus.tmu_s_primaryColor  = '0;
    bus.tmu_s_previousColor = '0;
    bus.tmu_s_textureS      = '0;
    bus.tmu_s_textureT      = '0;
    bus.m_user              = '0;
    bus.m_fragmentColor     = '0;
    if (!reset) begin
      bus.s_ready             = (state_q == IDLE);
      bus.tmu_s_valid         = (state_q == ISSUE);
      bus.tmu_m_ready         = (state_q == WAIT);
      bus.m_valid             = (state_q == OUTPUT);
      bus.tmu_s_stage         = stage_q;
      bus.tmu_s_primaryColor  = prim_q;
      bus.tmu_s_previousColor = prev_q;
      bus.tmu_s_textureS      = st_sel[63:32];
      bus.tmu_s_textureT      = st_sel[31:0];
      bus.m_user              = user_q;
      bus.m_fragmentColor     = prev_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      en_q    <= '0;
      user_q  <= '0;
      prim_q  <= '0;
      prev_q  <= '0;
      tex_q   <= '0;
      stage_q <= '0;
    end else if (in_hs) begin
      en_q    <= confStageEnable;
      user_q  <= bus.s_user;
      prim_q  <= bus.s_primaryColor;
      prev_q  <= bus.s_primaryColor;
      tex_q   <= bus.s_textureST;
      stage_q <= first_idx;
    end else if (rsp_hs) begin
      prev_q <= bus.tmu_m_fragmentColor;
      if (next_found) stage_q <= next_idx;
    end
  end
endmodule
